// File: rtl/oops_structs.sv
// -----------------------------------------------------------------------------
// oops_structs: shared types for the commit path.
//   TAG_W          - ROB tag width carried in owner table entries.
//   owner_entry_t  - {valid, tag}: which in-flight ROB tag last renamed a register.
//   commit_state_e - commit controller FSM states (RUN, RECOVER).
// -----------------------------------------------------------------------------
package oops_structs;

    localparam int TAG_W = 4;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } owner_entry_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } commit_state_e;

endpackage

// File: rtl/commit_owner_table.sv
// -----------------------------------------------------------------------------
// commit_owner_table: 32-entry register -> owning ROB tag table.
//   clk, rst  : clock, synchronous active-high reset (clears the table).
//   clear     : synchronous clear of every entry (flush).
//   rd_idx    : per-lane read index; rd_entry is the registered entry (comb read).
//   clr_en/clr_idx/clr_tag : per-lane compare-clear. The entry is invalidated
//               only if it is still owned by clr_tag.
//   set_en/set_idx/set_tag : per-lane write-set. Sets win over clears and the
//               highest lane wins among sets to the same index.
// Entry 0 (x0) is never valid.
// -----------------------------------------------------------------------------
module commit_owner_table
    import oops_structs::*;
#(
    parameter int LANES = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic [LANES-1:0][4:0]        rd_idx,
    output owner_entry_t [LANES-1:0]     rd_entry,
    input  logic [LANES-1:0]             clr_en,
    input  logic [LANES-1:0][4:0]        clr_idx,
    input  logic [LANES-1:0][TAG_W-1:0]  clr_tag,
    input  logic [LANES-1:0]             set_en,
    input  logic [LANES-1:0][4:0]        set_idx,
    input  logic [LANES-1:0][TAG_W-1:0]  set_tag
);

    owner_entry_t [31:0] owner_q;
    owner_entry_t [31:0] owner_d;

    always_comb begin
        owner_d = owner_q;
        // Compare against the registered owner so a clear from an older commit
        // cannot hit an entry a younger dispatch already re-owned.
        for (int i = 0; i < LANES; i++) begin
            if (clr_en[i] && owner_q[clr_idx[i]].valid &&
                owner_q[clr_idx[i]].tag == clr_tag[i]) begin
                owner_d[clr_idx[i]].valid = 1'b0;
            end
        end
        // Ascending loop: later (higher) lanes overwrite lower ones.
        for (int i = 0; i < LANES; i++) begin
            if (set_en[i]) begin
                owner_d[set_idx[i]] = '{valid: 1'b1, tag: set_tag[i]};
            end
        end
        owner_d[0] = '0;
        if (clear) begin
            owner_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= '0;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            rd_entry[i] = owner_q[rd_idx[i]];
        end
    end

endmodule

// File: rtl/commit_controller.sv
// -----------------------------------------------------------------------------
// commit_controller: sequences all architectural register file writes.
//   clk, rst              : clock, synchronous active-high reset.
//   dispatch_*            : rename requests (valid/rd/tag per lane), dispatch_ready_o.
//   rob_head_*            : completed ROB head entries, contiguous from lane 0.
//   flush_req_i           : external flush (exception).
//   commit_ack_o          : ROB pops the acked lanes.
//   rf_fls_o              : register file flush.
//   rf_commit_*           : register file commit lanes (write value, clear CB).
//   rf_speculate_*        : register file speculate lanes (set CB, record tag).
//   retired_count_o       : wrapping count of acked lanes.
//   debug_state           : current FSM state.
//
// Handshake: a dispatch lane is consumed in a cycle where dispatch_valid_i[i]
// and dispatch_ready_o are both 1; ready does not depend on dispatch_valid_i.
// A ROB head lane is consumed in a cycle where commit_ack_o[i] is 1;
// acks depend on the head valids but never the reverse.
//
// ROB_IDX_LEN must equal oops_structs::TAG_W (owner entries store the tag).
// -----------------------------------------------------------------------------
module commit_controller
    import oops_structs::*;
#(
    parameter int ISSUE_WIDTH    = 1,
    parameter int ROB_IDX_LEN    = TAG_W,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [ISSUE_WIDTH-1:0]                dispatch_valid_i,
    input  logic [ISSUE_WIDTH-1:0][4:0]           dispatch_rd_i,
    input  logic [ISSUE_WIDTH-1:0][ROB_IDX_LEN-1:0] dispatch_tag_i,
    output logic                                  dispatch_ready_o,
    input  logic [ISSUE_WIDTH-1:0]                rob_head_valid_i,
    input  logic [ISSUE_WIDTH-1:0][4:0]           rob_head_rd_i,
    input  logic [ISSUE_WIDTH-1:0][ROB_IDX_LEN-1:0] rob_head_tag_i,
    input  logic [ISSUE_WIDTH-1:0][31:0]          rob_head_data_i,
    input  logic [ISSUE_WIDTH-1:0]                rob_head_mispredict_i,
    input  logic                                  flush_req_i,
    output logic [ISSUE_WIDTH-1:0]                commit_ack_o,
    output logic                                  rf_fls_o,
    output logic [ISSUE_WIDTH-1:0]                rf_commit_o,
    output logic [ISSUE_WIDTH-1:0][4:0]           rf_commit_idx_o,
    output logic [ISSUE_WIDTH-1:0][31:0]          rf_commit_data_o,
    output logic [ISSUE_WIDTH-1:0]                rf_speculate_o,
    output logic [ISSUE_WIDTH-1:0][4:0]           rf_speculate_idx_o,
    output logic [ISSUE_WIDTH-1:0][ROB_IDX_LEN-1:0] rf_speculate_data_o,
    output logic [31:0]                           retired_count_o,
    output commit_state_e                         debug_state
);

    localparam logic [3:0] RC_LOAD = 4'(RECOVER_CYCLES);

    commit_state_e state_q;
    logic [3:0]    rc_q;

    owner_entry_t [ISSUE_WIDTH-1:0]    owner_rd;
    logic [ISSUE_WIDTH-1:0]            ack;
    logic [ISSUE_WIDTH-1:0]            reassert;
    logic [ISSUE_WIDTH-1:0]            set_en;
    logic [ISSUE_WIDTH-1:0]            clr_en;
    logic                              run_active;
    logic                              chain_ok;
    logic                              mispredict_hit;
    logic                              flush_trig;

    always_comb begin
        run_active     = !rst && (state_q == RUN);
        ack            = '0;
        mispredict_hit = 1'b0;
        // An external flush takes the whole cycle: nothing commits.
        chain_ok       = run_active && !flush_req_i;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            ack[i] = chain_ok && rob_head_valid_i[i];
            if (ack[i] && rob_head_mispredict_i[i]) begin
                mispredict_hit = 1'b1;
            end
            // The mispredict lane itself commits; nothing above it does.
            chain_ok = ack[i] && !rob_head_mispredict_i[i];
        end
        flush_trig = run_active && (flush_req_i || mispredict_hit);

        // A younger owner still exists: re-speculate so CB stays set after
        // the commit clears it in the register file.
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            reassert[i] = ack[i] && !flush_trig && owner_rd[i].valid &&
                          (owner_rd[i].tag != rob_head_tag_i[i]);
        end

        dispatch_ready_o = run_active && !flush_trig && (reassert == '0);

        rf_fls_o            = flush_trig;
        commit_ack_o        = ack;
        rf_commit_o         = '0;
        rf_commit_idx_o     = '0;
        rf_commit_data_o    = '0;
        rf_speculate_o      = '0;
        rf_speculate_idx_o  = '0;
        rf_speculate_data_o = '0;
        set_en              = '0;
        clr_en              = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (ack[i] && rob_head_rd_i[i] != 5'd0) begin
                rf_commit_o[i]      = 1'b1;
                rf_commit_idx_o[i]  = rob_head_rd_i[i];
                rf_commit_data_o[i] = rob_head_data_i[i];
            end
            clr_en[i] = ack[i] && !flush_trig;
            if (reassert[i]) begin
                rf_speculate_o[i]      = 1'b1;
                rf_speculate_idx_o[i]  = rob_head_rd_i[i];
                rf_speculate_data_o[i] = owner_rd[i].tag;
            end else if (dispatch_ready_o && dispatch_valid_i[i]) begin
                rf_speculate_o[i]      = 1'b1;
                rf_speculate_idx_o[i]  = dispatch_rd_i[i];
                rf_speculate_data_o[i] = dispatch_tag_i[i];
                set_en[i]              = dispatch_rd_i[i] != 5'd0;
            end
        end
    end

    commit_owner_table #(
        .LANES (ISSUE_WIDTH)
    ) u_owner (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush_trig),
        .rd_idx   (rob_head_rd_i),
        .rd_entry (owner_rd),
        .clr_en   (clr_en),
        .clr_idx  (rob_head_rd_i),
        .clr_tag  (rob_head_tag_i),
        .set_en   (set_en),
        .set_idx  (dispatch_rd_i),
        .set_tag  (dispatch_tag_i)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= RUN;
            rc_q            <= '0;
            retired_count_o <= '0;
        end else begin
            retired_count_o <= retired_count_o + 32'($countones(ack));
            case (state_q)
                RUN: begin
                    if (flush_trig) begin
                        state_q <= RECOVER;
                        rc_q    <= RC_LOAD;
                    end
                end
                RECOVER: begin
                    if (flush_req_i) begin
                        rc_q <= RC_LOAD;
                    end else if (rc_q == 4'd1) begin
                        state_q <= RUN;
                        rc_q    <= '0;
                    end else begin
                        rc_q <= rc_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= RUN;
                    rc_q    <= '0;
                end
            endcase
        end
    end

    assign debug_state = state_q;

endmodule
